// File: rtl/store_narrow_rmw.sv
// ----------------------------------------------------------------------------
// store_narrow_rmw
//
// Purpose:
//   Narrows a 32-bit register value to a byte, halfword or word store and
//   writes it into a word-wide data memory that has no byte enables. Word
//   stores are written directly. Byte and halfword stores read the target
//   word, merge the new lane(s) little-endian, then write the merged word.
//
// Ports:
//   clk, rst_n     - single rising-edge clock, asynchronous active-low reset
//   req_valid      - store request valid
//   req_ready      - block idle and able to accept a request
//   req_addr       - byte address of the store
//   req_data       - register value to store (upper bits ignored for narrow)
//   req_size       - 00 byte, 01 half, 10 word, 11 reserved (rejected)
//   mem_addr       - word address (req_addr with bits [1:0] cleared)
//   mem_rd_en      - one-cycle read strobe
//   mem_rd_data    - read data from memory
//   mem_rd_valid   - read data valid (only looked at while waiting for it)
//   mem_wr_en      - one-cycle write strobe
//   mem_wr_data    - merged write word, registered
//   done           - one-cycle pulse, store committed (same cycle as write)
//   misalign_err   - one-cycle pulse, request rejected
//   timeout_err    - one-cycle pulse, read timed out
//
// Build option:
//   STORE_RMW_TIMEOUT_EN - when defined, the read wait is bounded by
//   TIMEOUT_CYCLES; on expiry the store is abandoned with timeout_err.
//   When undefined the read wait is unbounded and timeout_err is tied 0.
// ----------------------------------------------------------------------------
module store_narrow_rmw #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  done,
    output logic                  misalign_err,
    output logic                  timeout_err
);

    // Lane arithmetic below assumes four byte lanes.
    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("store_narrow_rmw: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR      = 3'd4
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Reserved size is treated as misaligned so it is rejected the same way.
    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian lane merge: lane k is bits [8k+7:8k].
    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] rd,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [1:0]            size,
        input logic [1:0]            off
    );
        logic [DATA_WIDTH-1:0] m;
        m = rd;
        case (size)
            SIZE_BYTE: m[{off, 3'b000} +: 8] = wd[7:0];
            SIZE_HALF: begin
                if (off[1]) begin
                    m[31:16] = wd[15:0];
                end else begin
                    m[15:0] = wd[15:0];
                end
            end
            default:   m = wd;
        endcase
        return m;
    endfunction

    state_e                  state_q, state_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic                    req_ready_q, req_ready_d;
    logic                    mem_rd_en_q, mem_rd_en_d;
    logic                    mem_wr_en_q, mem_wr_en_d;
    logic                    done_q, done_d;
    logic                    misalign_err_q, misalign_err_d;
`ifdef STORE_RMW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_err_q, timeout_err_d;
`endif

    // Next-state and next-output logic; outputs are registered so each
    // strobe is computed from the state being entered.
    always_comb begin
        state_d        = state_q;
        off_d          = off_q;
        size_d         = size_q;
        data_d         = data_q;
        mem_addr_d     = mem_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        misalign_err_d = 1'b0;
`ifdef STORE_RMW_TIMEOUT_EN
        cnt_d          = cnt_q;
        timeout_err_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d          = req_addr[1:0];
                    size_d         = req_size;
                    data_d         = req_data;
                    mem_addr_d     = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    // Raised now so the pulse lines up with the CHECK cycle.
                    misalign_err_d = is_misaligned(req_addr[1:0], req_size);
                    state_d        = ST_CHECK;
                end else begin
                    state_d        = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (is_misaligned(off_q, size_q)) begin
                    state_d       = ST_IDLE;
                end else if (size_q == SIZE_WORD) begin
                    mem_wr_data_d = data_q;
                    state_d       = ST_WR;
                end else begin
                    state_d       = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
`ifdef STORE_RMW_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_rd_valid) begin
                    mem_wr_data_d = merge_word(mem_rd_data, data_q, size_q, off_q);
                    state_d       = ST_WR;
`ifdef STORE_RMW_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d       = ST_RD_WAIT;
                end
`else
                end else begin
                    state_d       = ST_RD_WAIT;
                end
`endif
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
        mem_rd_en_d = (state_d == ST_RD_REQ);
        mem_wr_en_d = (state_d == ST_WR);
        done_d      = (state_d == ST_WR);
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            off_q          <= 2'b00;
            size_q         <= 2'b00;
            data_q         <= '0;
            mem_addr_q     <= '0;
            mem_wr_data_q  <= '0;
            req_ready_q    <= 1'b1;
            mem_rd_en_q    <= 1'b0;
            mem_wr_en_q    <= 1'b0;
            done_q         <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            off_q          <= off_d;
            size_q         <= size_d;
            data_q         <= data_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            req_ready_q    <= req_ready_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_wr_en_q    <= mem_wr_en_d;
            done_q         <= done_d;
            misalign_err_q <= misalign_err_d;
        end
    end

`ifdef STORE_RMW_TIMEOUT_EN
    // Read-wait counter and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ready    = req_ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd_en    = mem_rd_en_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign done         = done_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-path counterpart to the load-side sign/zero extension.
- Narrows a 32-bit register value to a byte, halfword or word and writes it into word-wide data memory.
- Data memory has no byte enables, so sub-word stores use a read-modify-write sequence.
- Sits between the EX/MEM stage store request and the data memory port.

Parameters:
- DATA_WIDTH, 32: register and memory word width; must be 32.
- ADDR_WIDTH, 32: byte address width.
- TIMEOUT_CYCLES, 16: read-wait limit; used only with the optional feature.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  store request valid.
- req_ready  output  1  block idle, can accept a request.
- req_addr  input  ADDR_WIDTH  byte address.
- req_data  input  DATA_WIDTH  register value to store.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_addr  output  ADDR_WIDTH  word address: req_addr with bits [1:0] forced to 0.
- mem_rd_en  output  1  one-cycle read strobe.
- mem_rd_data  input  DATA_WIDTH  read data.
- mem_rd_valid  input  1  read data valid.
- mem_wr_en  output  1  one-cycle write strobe.
- mem_wr_data  output  DATA_WIDTH  merged write word.
- done  output  1  one-cycle pulse: store committed.
- misalign_err  output  1  one-cycle pulse: request rejected.
- timeout_err  output  1  one-cycle pulse: read timed out (tied 0 without the feature).

Behaviour:
- Reset values: state IDLE, req_ready=1, mem_rd_en=mem_wr_en=done=misalign_err=timeout_err=0, mem_addr=0, mem_wr_data=0.
- States: IDLE, CHECK, RD_REQ, RD_WAIT, WR.
- IDLE:
  - req_ready=1; the only state that accepts requests.
  - Accept on req_valid && req_ready at edge T; register addr, data and size; go to CHECK.
- CHECK (cycle T+1), alignment check:
  - Misaligned cases: size 11; half with addr[0]=1; word with addr[1:0]!=0.
  - Misaligned: misalign_err=1 this cycle; go to IDLE; no memory access.
  - Aligned word: go to WR.
  - Aligned byte or half: go to RD_REQ.
- RD_REQ: mem_rd_en=1 for exactly one cycle; go to RD_WAIT.
- RD_WAIT:
  - mem_rd_valid is sampled only in this state; valid in the RD_REQ cycle is ignored.
  - On mem_rd_valid, capture mem_rd_data and merge; go to WR.
  - Without the feature, waits indefinitely.
- Merge (little-endian, lane k = bits [8k+7:8k]):
  - Byte: lane addr[1:0] gets req_data[7:0].
  - Half: lanes {2*addr[1]+1, 2*addr[1]} get req_data[15:0].
  - Other lanes keep read data.
  - Upper req_data bits beyond the stored size are ignored (truncation, no check).
- WR:
  - mem_wr_en=1 and done=1 in the same cycle; mem_wr_data registered and stable; go to IDLE.
  - Aligned word latency: done at T+2.
  - Sub-word with 1-cycle read latency: done at T+4.
- mem_addr is driven from the registered address from CHECK through WR; it holds its value in IDLE.
- req_ready=0 in all non-IDLE states; a request held valid during busy is accepted on return to IDLE.
- Async reset mid-operation: immediate return to reset values; no partial write is issued.

Optional Feature:
- Macro: STORE_RMW_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to RD_WAIT and increments each RD_WAIT cycle.
  - If TIMEOUT_CYCLES cycles elapse without mem_rd_valid: timeout_err pulses one cycle, go to IDLE, no write, no done.
  - A late mem_rd_valid arriving in IDLE is ignored.
- Undefined: no counter; timeout_err tied 0; RD_WAIT waits forever.

Test Plan:
- Word store, addr 0x100, data 0xDEADBEEF, size 10 -> no mem_rd_en; at T+2 mem_wr_en=1, mem_addr=0x100, mem_wr_data=0xDEADBEEF, done=1.
- Byte store, addr 0x103, data 0xFFFFFFA5, memory returns 0x11223344 one cycle after read -> mem_wr_data=0xA5223344, done at T+4.
- Half store, addr 0x202, data 0x0000CAFE, read 0x11223344 -> mem_wr_data=0xCAFE3344; and at addr 0x200 -> 0x1122CAFE.
- Misaligned: half at 0x201, word at 0x102, size 11 -> misalign_err pulse at T+1 each; mem_rd_en and mem_wr_en never asserted; req_ready back to 1 at T+2.
- rst_n low during RD_WAIT of a byte store -> outputs at reset values immediately; no mem_wr_en afterward; next word store completes normally.
- With STORE_RMW_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_rd_valid never asserted -> timeout_err one cycle after 16 RD_WAIT cycles; no write; req_ready=1 next cycle.
